// File: rtl/divu_gen.sv
`default_nettype none
// ============================================================================
// Module   : divu_gen
// Purpose  : Memory-mapped W-bit restoring divider (W/W and 2W/W, signed or
//            unsigned). Define DIVU_DIV0_TRAP_EN for a distinct D=0 trap (DVCR.DZ).
// Revision : 1.0 - initial release
// ============================================================================
module divu_gen #(
  parameter int          W    = 32,
  parameter logic [31:0] BASE = 32'hFFFFFF00
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         CE,
  input  logic [31:0]  IBUS_A,
  input  logic [W-1:0] IBUS_DI,
  output logic [W-1:0] IBUS_DO,
  input  logic         IBUS_WE,
  input  logic         IBUS_REQ,
  output logic         IBUS_BUSY,
  output logic         IBUS_ACT,
  output logic         IRQ,
  output logic [7:0]   VEC
);

  localparam int              c_cw   = $clog2(W);
  localparam logic [c_cw-1:0] c_last = c_cw'(W - 1);

  typedef enum logic [2:0] {IDLE, LOAD, ITER, FIX, DONE} state_t;
  state_t state_q, state_d;

  logic [W-1:0]    dvsr_q, dvdnth_q, dvdntl_q, vcr_q, dvdnth2_q, dvdntl2_q, do_q;
  logic            ovf_q, ovfie_q, uns_q, dz_q, busy_q, mirror_q;
  logic [W-1:0]    q_q, r_q, d_q;
  logic            sq_q, sr_q, ovf_run_q, dz_run_q;
  logic [c_cw-1:0] cnt_q;

  logic         w_sel, w_acc, w_wr, w_start;
  logic [2:0]   w_idx;
  logic [W-1:0] w_rdata, w_dvcr;

  assign w_sel   = IBUS_REQ && ({1'b0, IBUS_A} >= {1'b0, BASE})
                            && ({1'b0, IBUS_A} <  ({1'b0, BASE} + 33'd32));
  assign w_idx   = IBUS_A[4:2];
  // Bus accesses only complete while the divider is idle; otherwise they are stalled.
  assign w_acc   = w_sel && (state_q == IDLE);
  assign w_wr    = w_acc && IBUS_WE;
  assign w_start = w_wr && ((w_idx == 3'd1) || (w_idx == 3'd5));
  assign w_dvcr  = {{(W-4){1'b0}}, dz_q, uns_q, ovfie_q, ovf_q};

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      3'd0:    w_rdata = dvsr_q;
      3'd1:    w_rdata = dvdntl_q;
      3'd2:    w_rdata = w_dvcr;
      3'd3:    w_rdata = vcr_q;
      3'd4:    w_rdata = dvdnth_q;
      3'd5:    w_rdata = dvdntl_q;
      3'd6:    w_rdata = dvdnth2_q;
      default: w_rdata = dvdntl2_q;
    endcase
  end

  logic [2*W-1:0] w_n, w_absn;
  logic [W-1:0]   w_absd;
  logic           w_sn, w_sd, w_early, w_dz;

  assign w_n     = {dvdnth_q, dvdntl_q};
  assign w_sn    = !uns_q && w_n[2*W-1];
  assign w_sd    = !uns_q && dvsr_q[W-1];
  assign w_absn  = w_sn ? -w_n : w_n;
  assign w_absd  = w_sd ? -dvsr_q : dvsr_q;
  assign w_early = (w_absn[2*W-1:W] >= w_absd);
`ifdef DIVU_DIV0_TRAP_EN
  assign w_dz    = (dvsr_q == '0);
`else
  assign w_dz    = 1'b0;
`endif

  logic [W:0]   w_rsh;
  logic [W-1:0] w_rsub, w_qfix, w_rfix, w_sat;
  logic         w_bit, w_late;

  assign w_rsh  = {r_q, q_q[W-1]};
  assign w_rsub = w_rsh[W-1:0] - d_q;
  assign w_bit  = (w_rsh >= {1'b0, d_q});
  // Magnitude 2^(W-1) is representable only as a negative quotient.
  assign w_late = !uns_q && q_q[W-1] && (!sq_q || (|q_q[W-2:0]));
  assign w_qfix = sq_q ? -q_q : q_q;
  assign w_rfix = sr_q ? -r_q : r_q;
  assign w_sat  = uns_q ? '1 : (sq_q ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}});

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (w_start) state_d = LOAD;
      LOAD:    state_d = (w_early || w_dz) ? DONE : ITER;
      ITER:    if (cnt_q == c_last) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)     state_q <= IDLE;
    else if (CE) state_q <= state_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dvsr_q    <= '0;  dvdnth_q  <= '0;  dvdntl_q  <= '0;  vcr_q    <= '0;
      dvdnth2_q <= '0;  dvdntl2_q <= '0;  do_q      <= '0;
      ovf_q     <= 1'b0; ovfie_q  <= 1'b0; uns_q     <= 1'b0; dz_q     <= 1'b0;
      busy_q    <= 1'b0; mirror_q <= 1'b0;
      q_q       <= '0;  r_q       <= '0;  d_q       <= '0;  cnt_q    <= '0;
      sq_q      <= 1'b0; sr_q     <= 1'b0; ovf_run_q <= 1'b0; dz_run_q <= 1'b0;
    end else if (CE) begin
      busy_q   <= w_sel && (state_q != IDLE);
      do_q     <= (w_acc && !IBUS_WE) ? w_rdata : '0;
      mirror_q <= (state_q == DONE);
      if (mirror_q) begin
        dvdnth2_q <= dvdnth_q;
        dvdntl2_q <= dvdntl_q;
      end
      if (w_wr) begin
        case (w_idx)
          3'd0: dvsr_q <= IBUS_DI;
          3'd1: begin
            dvdnth_q <= {W{!uns_q && IBUS_DI[W-1]}};
            dvdntl_q <= IBUS_DI;
          end
          3'd2: begin
            ovf_q   <= ovf_q & IBUS_DI[0];
            ovfie_q <= IBUS_DI[1];
            uns_q   <= IBUS_DI[2];
            dz_q    <= dz_q & IBUS_DI[3];
          end
          3'd3:    vcr_q    <= IBUS_DI;
          3'd4:    dvdnth_q <= IBUS_DI;
          3'd5:    dvdntl_q <= IBUS_DI;
          default: ;
        endcase
      end
      // Placed after the bus write so a hardware flag set takes priority.
      case (state_q)
        LOAD: begin
          sq_q      <= w_sn ^ w_sd;
          sr_q      <= w_sn;
          d_q       <= w_absd;
          r_q       <= w_absn[2*W-1:W];
          q_q       <= w_absn[W-1:0];
          cnt_q     <= '0;
          dz_run_q  <= w_dz;
          ovf_run_q <= w_early && !w_dz;
        end
        ITER: begin
          r_q   <= w_bit ? w_rsub : w_rsh[W-1:0];
          q_q   <= {q_q[W-2:0], w_bit};
          cnt_q <= cnt_q + c_cw'(1);
        end
        FIX: begin
          q_q       <= w_qfix;
          r_q       <= w_rfix;
          ovf_run_q <= w_late;
        end
        DONE: begin
          if (dz_run_q) begin
            dz_q     <= 1'b1;
            dvdntl_q <= '1;
          end else if (ovf_run_q) begin
            ovf_q <= 1'b1;
            if (!ovfie_q) dvdntl_q <= w_sat;
          end else begin
            dvdntl_q <= q_q;
            dvdnth_q <= r_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign IBUS_DO   = do_q;
  assign IBUS_BUSY = busy_q;
  assign IBUS_ACT  = w_sel;
  assign IRQ       = (ovf_q | dz_q) & ovfie_q;
  assign VEC       = vcr_q[7:0];

endmodule
`default_nettype wire

// File: tb/tb_divu_gen.sv
`default_nettype none
// tb_divu_gen: directed and randomized self-checking bench for divu_gen at W=32,
// with expectations from an arithmetic reference model.
module tb_divu_gen;
  localparam logic [31:0] BASE = 32'hFFFFFF00;

  logic        clk, rst, ce, we, req, busy, act, irq;
  logic [31:0] a, di, dout;
  logic [7:0]  vec;
  int          checks = 0;
  int          failures = 0;

  divu_gen #(.W(32), .BASE(BASE)) dut (
    .CLK(clk), .RST(rst), .CE(ce), .IBUS_A(a), .IBUS_DI(di), .IBUS_DO(dout),
    .IBUS_WE(we), .IBUS_REQ(req), .IBUS_BUSY(busy), .IBUS_ACT(act),
    .IRQ(irq), .VEC(vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One bus access; returns read data and the number of edges until it completed.
  task automatic acc(input int idx, input bit is_wr, input logic [31:0] data,
                     output logic [31:0] rdata, output int ncyc);
    a = BASE + 32'(idx * 4); we = is_wr; di = data; req = 1'b1; ncyc = 0;
    do begin
      @(posedge clk); #1; ncyc++;
    end while (busy && ncyc < 300);
    if (busy) begin
      failures++;
      $error("FAIL bus_timeout observed=busy expected=idle");
    end
    rdata = dout; req = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input int idx, input logic [31:0] data);
    logic [31:0] v; int n;
    acc(idx, 1'b1, data, v, n);
  endtask

  task automatic rdreg(input int idx, output logic [31:0] v);
    int n;
    acc(idx, 1'b0, 32'd0, v, n);
  endtask

  // Reference: truncating division from magnitudes, overflow by quotient range.
  function automatic void model(input logic [31:0] h, l, d, input bit uns, ovfie,
                                output logic [31:0] eh, el, output bit eovf, edz,
                                output int ecyc);
    logic [63:0] n, an, ad, aq, ar;
    bit sn, sd, sq;
    n = {h, l}; eh = h; el = l; eovf = 1'b0; edz = 1'b0;
    sn = !uns && n[63];
    sd = !uns && d[31];
    an = sn ? -n : n;
    ad = sd ? {32'd0, -d} : {32'd0, d};
    sq = sn ^ sd;
    if (d == 32'd0) begin
      ecyc = 3;
`ifdef DIVU_DIV0_TRAP_EN
      edz = 1'b1; el = 32'hFFFFFFFF;
      return;
`else
      eovf = 1'b1;
`endif
    end else begin
      aq = an / ad; ar = an % ad;
      ecyc = (aq > 64'hFFFFFFFF) ? 3 : 36;
      if (uns) eovf = (aq > 64'hFFFFFFFF);
      else     eovf = sq ? (aq > 64'h80000000) : (aq > 64'h7FFFFFFF);
      if (!eovf) begin
        el = sq ? 32'(-aq) : aq[31:0];
        eh = sn ? 32'(-ar) : ar[31:0];
      end
    end
    if (eovf && !ovfie) el = uns ? 32'hFFFFFFFF : (sq ? 32'h80000000 : 32'h7FFFFFFF);
  endfunction

  task automatic dir_case(input string tag, input bit uns, ovfie, two_w,
                          input logic [31:0] h, l, d, el, eh, ecr, input int ecyc);
    logic [31:0] v; int n;
    wr(2, {29'd0, uns, ovfie, 1'b0});
    wr(0, d);
    if (two_w) begin wr(4, h); wr(5, l); end
    else wr(1, l);
    acc(5, 1'b0, 32'd0, v, n);
    check($sformatf("%s.cycles", tag), 32'(n), 32'(ecyc));
    check($sformatf("%s.DVDNTL", tag), v, el);
    rdreg(4, v); check($sformatf("%s.DVDNTH", tag), v, eh);
    rdreg(2, v); check($sformatf("%s.DVCR", tag), v, ecr);
    check($sformatf("%s.IRQ", tag), {31'd0, irq}, {31'd0, (ecr[0] | ecr[3]) & ovfie});
    rdreg(7, v); check($sformatf("%s.DVDNTL2", tag), v, el);
    rdreg(6, v); check($sformatf("%s.DVDNTH2", tag), v, eh);
  endtask

  task automatic run_case(input string tag, input bit uns, ovfie, two_w,
                          input logic [31:0] h, l, d);
    logic [31:0] eh, el, hh; bit eovf, edz; int ecyc;
    hh = two_w ? h : (uns ? 32'd0 : {32{l[31]}});
    model(hh, l, d, uns, ovfie, eh, el, eovf, edz, ecyc);
    dir_case(tag, uns, ovfie, two_w, h, l, d, el, eh,
             {28'd0, edz, uns, ovfie, eovf}, ecyc);
  endtask

  initial begin
    logic [31:0] v, h, l, d;
    int n, sel;
    rst = 1'b1; ce = 1'b1; req = 1'b0; we = 1'b0; a = 32'd0; di = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.BUSY", {31'd0, busy}, 32'd0);
    check("rst.IRQ",  {31'd0, irq},  32'd0);
    check("rst.VEC",  {24'd0, vec},  32'd0);
    check("rst.DO",   dout,          32'd0);
    rst = 1'b0;
    rdreg(2, v); check("rst.DVCR", v, 32'd0);
    rdreg(0, v); check("rst.DVSR", v, 32'd0);

    a = BASE + 32'd28; req = 1'b1; #1 check("act.in",   {31'd0, act}, 32'd1);
    a = BASE + 32'd32;             #1 check("act.hi",   {31'd0, act}, 32'd0);
    a = BASE - 32'd4;              #1 check("act.lo",   {31'd0, act}, 32'd0);
    req = 1'b0;

    dir_case("s100_7",  1'b0, 1'b0, 1'b0, 32'd0, 32'd100, 32'd7,
             32'd14, 32'd2, 32'd0, 36);
    dir_case("neg7_2",  1'b0, 1'b0, 1'b0, 32'd0, 32'hFFFFFFF9, 32'd2,
             32'hFFFFFFFD, 32'hFFFFFFFF, 32'd0, 36);
    dir_case("lateovf", 1'b0, 1'b0, 1'b1, 32'd1, 32'd0, 32'd2,
             32'h7FFFFFFF, 32'd1, 32'd1, 36);
    dir_case("uns2w",   1'b1, 1'b0, 1'b1, 32'd1, 32'd0, 32'd2,
             32'h80000000, 32'd0, 32'd4, 36);
    dir_case("earlyie", 1'b0, 1'b1, 1'b1, 32'd5, 32'd9, 32'd3,
             32'd9, 32'd5, 32'd3, 3);
`ifdef DIVU_DIV0_TRAP_EN
    dir_case("div0", 1'b0, 1'b0, 1'b0, 32'd0, 32'd1, 32'd0,
             32'hFFFFFFFF, 32'd0, 32'd8, 3);
`else
    dir_case("div0", 1'b0, 1'b0, 1'b0, 32'd0, 32'd1, 32'd0,
             32'h7FFFFFFF, 32'd0, 32'd1, 3);
`endif

    // Clock enable low must freeze the run.
    wr(2, 32'd0); wr(0, 32'd7); wr(1, 32'd100);
    ce = 1'b0;
    repeat (5) @(posedge clk);
    #1 ce = 1'b1;
    acc(5, 1'b0, 32'd0, v, n);
    check("ce.cycles", 32'(n), 32'd36);
    check("ce.DVDNTL", v, 32'd14);

    // Asynchronous reset in the middle of a run.
    dir_case("pre_rst", 1'b0, 1'b1, 1'b1, 32'd5, 32'd9, 32'd3,
             32'd9, 32'd5, 32'd3, 3);
    wr(3, 32'h000000A5);
    check("vcr.VEC", {24'd0, vec}, 32'h000000A5);
    wr(0, 32'd7); wr(1, 32'd100);
    a = BASE + 32'd20; we = 1'b0; req = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("midrun.BUSY", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("arst.BUSY", {31'd0, busy}, 32'd0);
    check("arst.IRQ",  {31'd0, irq},  32'd0);
    check("arst.VEC",  {24'd0, vec},  32'd0);
    check("arst.DO",   dout,          32'd0);
    req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    rdreg(5, v); check("arst.DVDNTL", v, 32'd0);
    dir_case("post_rst", 1'b0, 1'b0, 1'b0, 32'd0, 32'd100, 32'd7,
             32'd14, 32'd2, 32'd0, 36);

    for (int i = 0; i < 16; i++) begin
      sel = int'($urandom_range(0, 7));
      if (sel == 0)     d = 32'd0;
      else if (sel < 4) d = $urandom_range(1, 15);
      else              d = $urandom;
      if (sel > 0 && sel < 4 && $urandom_range(0, 1) == 1) d = -d;
      case ($urandom_range(0, 3))
        0:       h = $urandom;
        1:       h = 32'd0;
        2:       h = 32'hFFFFFFFF;
        default: h = $urandom_range(0, 7);
      endcase
      l = $urandom;
      run_case($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), h, l, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
